// File: rtl/mult_div_unit_if.sv
// Request/result bundle between control and the iterative
// multiply/divide unit (operands in, HI/LO and status out).
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers:
// magnitude shift-add / restoring divide, sign fix at the end.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  mult_div_unit_if.slave bus
);
  localparam int W  = WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          is_div;
  logic          div0;
  logic          neg_q;
  logic          neg_r;
  logic [W-1:0]  a_orig;
  logic [W-1:0]  dvs;
  logic [2*W-1:0] acc;
  logic [W:0]    rem;
  logic          busy_q;
  logic          done_q;
  logic [W-1:0]  hi_q;
  logic [W-1:0]  lo_q;

  logic          sgn;
  logic [W-1:0]  abs_a;
  logic [W-1:0]  abs_b;
  logic [W:0]    add_sum;
  logic [W+1:0]  shifted;
  logic [W+1:0]  trial;
  logic [2*W-1:0] prod;
  logic [W-1:0]  q_fix;
  logic [W-1:0]  r_fix;

  always_comb begin
    sgn     = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    abs_a   = (sgn && bus.a[W-1]) ? -bus.a : bus.a;
    abs_b   = (sgn && bus.b[W-1]) ? -bus.b : bus.b;
    add_sum = {1'b0, acc[2*W-1:W]}
            + {1'b0, (acc[0] ? dvs : '0)};
    // One spare top bit makes the borrow of the trial
    // subtraction its sign bit.
    shifted = {rem, acc[W-1]};
    trial   = shifted - {2'b00, dvs};
    prod    = neg_q ? -acc : acc;
    q_fix   = neg_q ? -acc[W-1:0] : acc[W-1:0];
    r_fix   = neg_r ? -rem[W-1:0] : rem[W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      div0   <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      a_orig <= '0;
      dvs    <= '0;
      acc    <= '0;
      rem    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_MTHI: hi_q <= bus.a;
              OP_MTLO: lo_q <= bus.a;
              OP_MULT, OP_MULTU: begin
                is_div <= 1'b0;
                neg_q  <= sgn & (bus.a[W-1] ^ bus.b[W-1]);
                neg_r  <= 1'b0;
                div0   <= 1'b0;
                dvs    <= abs_a;
                acc    <= {{W{1'b0}}, abs_b};
                rem    <= '0;
                cnt    <= '0;
                busy_q <= 1'b1;
                state  <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                is_div <= 1'b1;
                neg_q  <= sgn & (bus.a[W-1] ^ bus.b[W-1]);
                neg_r  <= sgn & bus.a[W-1];
                div0   <= (bus.b == '0);
                a_orig <= bus.a;
                dvs    <= abs_b;
                acc    <= {{W{1'b0}}, abs_a};
                rem    <= '0;
                cnt    <= '0;
                busy_q <= 1'b1;
                state  <= RUN;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          if (is_div) begin
            if (!trial[W+1]) rem <= trial[W:0];
            else             rem <= shifted[W:0];
            acc <= {acc[2*W-1:W], acc[W-2:0],
                    ~trial[W+1]};
          end else begin
            acc <= {add_sum, acc[W-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) state <= FINISH;
        end
        FINISH: begin
          if (!is_div) begin
            hi_q <= prod[2*W-1:W];
            lo_q <= prod[W-1:0];
          end else if (div0) begin
            hi_q <= a_orig;
            lo_q <= '1;
          end else begin
            hi_q <= r_fix;
            lo_q <= q_fix;
          end
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule
